// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: owner tags, priority encoding, line geometry.
// Round-robin arbitration is enabled with `define MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic {
    PRI_D  = 1'b0,
    PRI_IF = 1'b1
  } prio_e;

  localparam int LINE_W_DEF  = 128;
  localparam int ADDR_W_DEF  = 32;
  localparam int DEPTH_W_DEF = 12;

  function automatic int mask_w(input int line_w);
    return line_w / 8;
  endfunction

  // Byte-offset bits below the line index inside a byte address.
  function automatic int line_off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_hi(input int line_w, input int depth_w);
    return line_off_w(line_w) + depth_w - 1;
  endfunction

endpackage

// File: rtl/mem_arb_tagpipe.sv
// Latency-matched owner-tag shift register; kill scrubs fetch tags.
// Exit tag lines up with RAM read data RD_LAT cycles after the grant.
module mem_arb_tagpipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   CLK,
  input  logic   RST,
  input  owner_e push,
  input  logic   kill,
  output owner_e exit_tag
);

  owner_e stage [RD_LAT];

  function automatic owner_e scrub(input owner_e t, input logic k);
    return (k && t == OWN_IF) ? OWN_NONE : t;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= OWN_NONE;
      end
    end else begin
      stage[0] <= scrub(push, kill);
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= scrub(stage[i-1], kill);
      end
    end
  end

  assign exit_tag = stage[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port fetch/data arbiter over a single-port line RAM.
// `define MEM_ARB_RR_EN selects round-robin, else data port wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int DEPTH_W = DEPTH_W_DEF,
  parameter int RD_LAT  = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  input  logic                if_kill,
  output logic                if_rvalid,
  output logic [LINE_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [LINE_W-1:0]   d_wdata,
  input  logic [LINE_W/8-1:0] d_wmask,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [LINE_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DEPTH_W-1:0]  mem_addr,
  output logic [LINE_W-1:0]   mem_wdata,
  output logic [LINE_W/8-1:0] mem_wmask,
  input  logic [LINE_W-1:0]   mem_rdata
);

  localparam int IDX_LO = line_off_w(LINE_W);
  localparam int IDX_HI = idx_hi(LINE_W, DEPTH_W);

  logic   req_if;
  logic   req_d;
  logic   gnt_if;
  logic   gnt_d;
  owner_e push_tag;
  owner_e exit_tag;

  assign req_if = if_req & ~RST;
  assign req_d  = d_req & ~RST;

`ifdef MEM_ARB_RR_EN
  prio_e prio;

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (req_if && req_d) begin
      gnt_d  = (prio == PRI_D);
      gnt_if = (prio == PRI_IF);
    end else begin
      gnt_d  = req_d;
      gnt_if = req_if;
    end
  end

  // Priority flips to the other port after every grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prio <= PRI_D;
    end else if (gnt_d) begin
      prio <= PRI_IF;
    end else if (gnt_if) begin
      prio <= PRI_D;
    end
  end
`else
  assign gnt_d  = req_d;
  assign gnt_if = req_if & ~req_d;
`endif

  assign if_gnt = gnt_if;
  assign d_gnt  = gnt_d;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (gnt_d) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr[IDX_HI:IDX_LO];
      mem_wdata = d_wdata;
      mem_wmask = d_wmask;
    end else if (gnt_if) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[IDX_HI:IDX_LO];
    end
  end

  always_comb begin
    push_tag = OWN_NONE;
    if (gnt_d && !d_we) begin
      push_tag = OWN_D;
    end else if (gnt_if) begin
      push_tag = OWN_IF;
    end
  end

  mem_arb_tagpipe #(
    .RD_LAT (RD_LAT)
  ) u_tagpipe (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push_tag),
    .kill     (if_kill),
    .exit_tag (exit_tag)
  );

  // A kill also hides the fetch response that exits in the same cycle.
  assign if_rvalid = (exit_tag == OWN_IF) & ~if_kill & ~RST;
  assign d_rvalid  = (exit_tag == OWN_D) & ~RST;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  logic unused_addr;
  assign unused_addr = ^{if_addr[IDX_LO-1:0], if_addr[ADDR_W-1:IDX_HI+1],
                         d_addr[IDX_LO-1:0], d_addr[ADDR_W-1:IDX_HI+1]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: line RAM model plus response scoreboard.
// Honours MEM_ARB_RR_EN for the expected conflict grant order.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 128;
  localparam int MW      = LINE_W / 8;
  localparam int DEPTH_W = 12;
  localparam int RD_LAT  = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              if_req, if_gnt, if_kill, if_rvalid;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [LINE_W-1:0] if_rdata, d_rdata, d_wdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [MW-1:0]     d_wmask, mem_wmask;
  logic              mem_en, mem_we;
  logic [DEPTH_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(
    .ADDR_W (ADDR_W), .LINE_W (LINE_W), .DEPTH_W (DEPTH_W), .RD_LAT (RD_LAT)
  ) dut (
    .CLK (CLK), .RST (RST),
    .if_req (if_req), .if_addr (if_addr), .if_gnt (if_gnt),
    .if_kill (if_kill), .if_rvalid (if_rvalid), .if_rdata (if_rdata),
    .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
    .d_wmask (d_wmask), .d_gnt (d_gnt), .d_rvalid (d_rvalid), .d_rdata (d_rdata),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_wmask (mem_wmask), .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    owner_e            own;
    logic [LINE_W-1:0] data;
    int                due;
    bit                killed;
  } rsp_t;

  rsp_t              sb[$];
  logic [LINE_W-1:0] ram   [256];
  logic [LINE_W-1:0] model [256];
  logic [LINE_W-1:0] rd_pipe [RD_LAT];
  bit                ram_init = 1'b0;
  bit                mdl_init = 1'b0;
  int                cyc = 0;
  int                n_chk = 0;
  int                n_pass = 0;
  int                n_fail = 0;

  function automatic logic [LINE_W-1:0] line_val(input int i);
    logic [LINE_W-1:0] v;
    for (int b = 0; b < MW; b++) v[b*8 +: 8] = 8'(i * 7 + b * 16 + 1);
    return v;
  endfunction

  function automatic int lidx(input logic [ADDR_W-1:0] a);
    return int'(a[11:4]);
  endfunction

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Line RAM with RD_LAT-cycle read pipeline
  always @(posedge CLK) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= line_val(i);
      ram_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < MW; b++)
        if (mem_wmask[b]) ram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[7:0]] : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Scoreboard: push on grant, pop and compare when the response is due
  always @(negedge CLK) begin : mon
    rsp_t r;
    logic exp_if, exp_d;
    logic [LINE_W-1:0] exp_data;
    if (!mdl_init) begin
      for (int i = 0; i < 256; i++) model[i] = line_val(i);
      mdl_init = 1'b1;
    end
    if (RST) begin
      chk("rst_if_gnt", 128'(if_gnt), 128'(0));
      chk("rst_d_gnt", 128'(d_gnt), 128'(0));
      chk("rst_mem_en", 128'(mem_en), 128'(0));
      chk("rst_if_rvalid", 128'(if_rvalid), 128'(0));
      chk("rst_d_rvalid", 128'(d_rvalid), 128'(0));
      sb.delete();
    end else begin
      exp_if = 1'b0;
      exp_d = 1'b0;
      exp_data = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        r = sb.pop_front();
        if (!r.killed) begin
          exp_if = (r.own == OWN_IF) && !if_kill;
          exp_d = (r.own == OWN_D);
          exp_data = r.data;
        end
      end
      chk($sformatf("if_rvalid@%0d", cyc), 128'(if_rvalid), 128'(exp_if));
      chk($sformatf("d_rvalid@%0d", cyc), 128'(d_rvalid), 128'(exp_d));
      if (exp_if) chk($sformatf("if_rdata@%0d", cyc), if_rdata, exp_data);
      if (exp_d) chk($sformatf("d_rdata@%0d", cyc), d_rdata, exp_data);
      if (if_kill)
        foreach (sb[i]) if (sb[i].own == OWN_IF) sb[i].killed = 1'b1;
      if (d_gnt) begin
        if (d_we) begin
          for (int b = 0; b < MW; b++)
            if (d_wmask[b]) model[lidx(d_addr)][b*8 +: 8] = d_wdata[b*8 +: 8];
        end else begin
          sb.push_back('{own: OWN_D, data: model[lidx(d_addr)],
                         due: cyc + RD_LAT, killed: 1'b0});
        end
      end else if (if_gnt) begin
        sb.push_back('{own: OWN_IF, data: model[lidx(if_addr)],
                       due: cyc + RD_LAT, killed: if_kill});
      end
    end
  end

  task automatic idle();
    if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  initial begin : stim
    logic exp_d;
    logic [LINE_W-1:0] l;
    int seen_if, seen_d;

    idle();
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h40;
    RST = 1'b1;
    repeat (2) next();
    idle();
    RST = 1'b0;

    // Write then read same line
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30;
    d_wdata = 128'hDEADC0DE; d_wmask = 16'h000F;
    @(negedge CLK);
    chk("wr_d_gnt", 128'(d_gnt), 128'(1));
    chk("wr_if_gnt", 128'(if_gnt), 128'(0));
    chk("wr_mem_we", 128'(mem_we), 128'(1));
    chk("wr_mem_addr", 128'(mem_addr), 128'(3));
    chk("wr_mem_wmask", 128'(mem_wmask), 128'(16'h000F));
    chk("wr_mem_wdata", mem_wdata, 128'hDEADC0DE);
    next();
    d_we = 1'b0; d_wmask = '0; d_wdata = '0;
    @(negedge CLK);
    chk("rd_d_gnt", 128'(d_gnt), 128'(1));
    chk("rd_mem_we", 128'(mem_we), 128'(0));
    chk("rd_mem_en", 128'(mem_en), 128'(1));
    next();
    idle();
    repeat (RD_LAT - 1) @(posedge CLK);
    @(negedge CLK);
    l = line_val(3);
    chk("rw_d_rvalid", 128'(d_rvalid), 128'(1));
    chk("rw_low_word", 128'(d_rdata[31:0]), 128'(32'hDEADC0DE));
    chk("rw_high_bytes", 128'(d_rdata[127:32]), 128'(l[127:32]));
    next();

    // Single fetch
    if_req = 1'b1; if_addr = 32'h20;
    @(negedge CLK);
    chk("sf_if_gnt", 128'(if_gnt), 128'(1));
    chk("sf_d_gnt", 128'(d_gnt), 128'(0));
    chk("sf_mem_addr", 128'(mem_addr), 128'(2));
    chk("sf_mem_we", 128'(mem_we), 128'(0));
    chk("sf_mem_wmask", 128'(mem_wmask), 128'(0));
    next();
    idle();
    repeat (RD_LAT - 1) @(posedge CLK);
    @(negedge CLK);
    chk("sf_if_rvalid", 128'(if_rvalid), 128'(1));
    chk("sf_if_rdata", if_rdata, line_val(2));
    chk("sf_d_rvalid", 128'(d_rvalid), 128'(0));
    next();

    // Conflict: both ports request for four cycles
    if_req = 1'b1; if_addr = 32'h50;
    d_req = 1'b1; d_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      chk($sformatf("cf_d_gnt%0d", k), 128'(d_gnt), 128'(exp_d));
      chk($sformatf("cf_if_gnt%0d", k), 128'(if_gnt), 128'(!exp_d));
      chk($sformatf("cf_mem_addr%0d", k), 128'(mem_addr), exp_d ? 128'(4) : 128'(5));
      next();
    end
    d_req = 1'b0;
    @(negedge CLK);
    chk("cf_if_after", 128'(if_gnt), 128'(1));
    next();
    idle();
    repeat (RD_LAT + 1) next();

    // Kill two in-flight fetches while a data read is granted
    if_req = 1'b1; if_addr = 32'h60;
    @(negedge CLK);
    chk("k_gnt0", 128'(if_gnt), 128'(1));
    next();
    if_addr = 32'h70;
    @(negedge CLK);
    chk("k_gnt1", 128'(if_gnt), 128'(1));
    next();
    if_req = 1'b0; if_kill = 1'b1;
    d_req = 1'b1; d_addr = 32'h80;
    @(negedge CLK);
    chk("k_d_gnt", 128'(d_gnt), 128'(1));
    next();
    idle();
    seen_if = 0; seen_d = 0;
    for (int k = 0; k < RD_LAT + 2; k++) begin
      @(negedge CLK);
      seen_if += int'(if_rvalid);
      seen_d += int'(d_rvalid);
    end
    chk("k_no_if_rvalid", 128'(seen_if), 128'(0));
    chk("k_d_rvalid_cnt", 128'(seen_d), 128'(1));
    next();

    // Kill on the exit cycle, with a fetch granted in that cycle
    if_req = 1'b1; if_addr = 32'h90;
    @(negedge CLK);
    chk("kx_gnt0", 128'(if_gnt), 128'(1));
    next();
    if_req = 1'b0;
    repeat (RD_LAT - 1) @(posedge CLK);
    #1;
    if_kill = 1'b1; if_req = 1'b1; if_addr = 32'hA0;
    @(negedge CLK);
    chk("kx_exit_rvalid", 128'(if_rvalid), 128'(0));
    chk("kx_gnt1", 128'(if_gnt), 128'(1));
    next();
    if_kill = 1'b0; if_addr = 32'hB0;
    @(negedge CLK);
    chk("kx_gnt2", 128'(if_gnt), 128'(1));
    next();
    idle();
    seen_if = 0;
    for (int k = 0; k < RD_LAT + 2; k++) begin
      @(negedge CLK);
      seen_if += int'(if_rvalid);
    end
    chk("kx_if_rvalid_cnt", 128'(seen_if), 128'(1));
    next();

    // Reset while a data read is in flight
    d_req = 1'b1; d_addr = 32'h20;
    @(negedge CLK);
    chk("mr_d_gnt", 128'(d_gnt), 128'(1));
    next();
    idle();
    RST = 1'b1;
    @(negedge CLK);
    chk("mr_mem_en", 128'(mem_en), 128'(0));
    chk("mr_mem_addr", 128'(mem_addr), 128'(0));
    next();
    RST = 1'b0;
    if_req = 1'b1; if_addr = 32'h50;
    d_req = 1'b1; d_addr = 32'h40;
    @(negedge CLK);
    chk("pr_d_gnt", 128'(d_gnt), 128'(1));
    chk("pr_if_gnt", 128'(if_gnt), 128'(0));
    chk("pr_d_rvalid", 128'(d_rvalid), 128'(0));
    next();
    idle();
    @(negedge CLK);
    chk("mr_no_rvalid", 128'(d_rvalid), 128'(0));
    repeat (RD_LAT + 3) next();
    @(negedge CLK);
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
